// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit signed ALU and its sweep controller:
// opcodes, widths, FSM state encoding, the operand-vector payload and the
// MISR next-state function.
package alu_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned SIG_W  = 8;
   localparam int unsigned IDX_W  = OP_W + 2 * DATA_W;
   localparam int unsigned CNT_W  = IDX_W + 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2047);

   // ALU opcode table
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
   localparam logic [OP_W-1:0] OP_NEG = OP_W'(2);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
   localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_XOR = OP_W'(5);
   localparam logic [OP_W-1:0] OP_NGT = OP_W'(6);  // y=1 iff !(a>b)
   localparam logic [OP_W-1:0] OP_EQ  = OP_W'(7);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   // One ALU stimulus vector; op is the most significant field so that a
   // plain increment walks op as the outer loop and b as the inner loop.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } alu_vec_t;

   // MISR step, polynomial x^8+x^6+x^5+x^4+1
   function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                  input logic [DATA_W-1:0] d);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {4'b0, d};
   endfunction

endpackage

// File: rtl/misr8.sv
// 8-bit multiple-input signature register.
//   clk, rst_n : clock, async active-low reset (resets to SIG_SEED)
//   load       : reload SIG_SEED (priority over en)
//   en         : absorb din into the signature
//   din        : 4-bit data folded into the low bits
//   q          : current signature
module misr8
   import alu_pkg::*;
#(
   parameter logic [SIG_W-1:0] SIG_SEED = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [SIG_W-1:0]  q
);

   // Signature register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SIG_SEED;
      end else if (load) begin
         q <= SIG_SEED;
      end else if (en) begin
         q <= misr_next(q, din);
      end
   end

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Exhaustive ALU sweep driver with signature check.
//   clk, rst_n         : clock, async active-low reset
//   start              : request a sweep (sampled in IDLE only)
//   golden_sig         : expected final signature
//   alu_op/alu_a/alu_b : registered ALU stimulus
//   alu_y              : ALU result (combinational from the stimulus)
//   busy, done, pass   : run status, completion pulse, signature match
//   sig, vec_cnt       : running signature and vectors absorbed
module alu_sweep_ctrl
   import alu_pkg::*;
#(
   parameter logic [SIG_W-1:0] SIG_SEED = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SIG_W-1:0]  golden_sig,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  sig,
   output logic [CNT_W-1:0]  vec_cnt
);

   state_e            state_q, state_d;
   alu_vec_t          vec_q, vec_d;
   logic              busy_d, done_d, pass_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              misr_load, misr_en;

   // The vector register is the ALU stimulus; it is zero outside RUN
   // because it wraps to 0 on the last RUN edge and only moves in RUN.
   assign alu_op = vec_q.op;
   assign alu_a  = vec_q.a;
   assign alu_b  = vec_q.b;

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      busy_d    = busy;
      done_d    = 1'b0;
      pass_d    = pass;
      cnt_d     = vec_cnt;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               vec_d     = '0;
               busy_d    = 1'b1;
               cnt_d     = '0;
               pass_d    = 1'b0;
               misr_load = 1'b1;
            end
         end
         RUN: begin
            misr_en = 1'b1;
            cnt_d   = vec_cnt + CNT_W'(1);
            vec_d   = alu_vec_t'(IDX_W'(vec_q) + IDX_W'(1));
            if (IDX_W'(vec_q) == IDX_LAST) begin
               state_d = FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               // compare against the value being written so the final
               // vector is included
               pass_d  = (misr_next(sig, alu_y) == golden_sig);
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         vec_cnt <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         busy    <= busy_d;
         done    <= done_d;
         pass    <= pass_d;
         vec_cnt <= cnt_d;
      end
   end

   misr8 #(
      .SIG_SEED (SIG_SEED)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (misr_load),
      .en    (misr_en),
      .din   (alu_y),
      .q     (sig)
   );

endmodule
